ram_port_arbiter: RTL

//  Shares one 2048x16 simple-dual-port block RAM between two requesters
//  (e.g. front-panel switch path and UART loader). Grants one read or write
//  per cycle with round-robin fairness, returns read data with fixed latency,
//  and optionally zero-fills the RAM after reset. Sits between the requesters
//  and the RAM's write/read ports. Both RAM ports are clocked by clk.

---
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a simple-dual-port RAM.
// Optional post-reset zero-fill; reads return one cycle after accept.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata  requester N operation (held until ready)
//   reqN_ready                operation accepted this cycle
//   rspN_valid/rdata          read data pulse, one cycle after accept
//   ram_wren/wraddr/di        RAM write port (zeroed when idle)
//   ram_rden/rdaddr           RAM read port (zeroed when idle)
//   ram_do                    registered RAM read data
module ram_port_arbiter #(
  parameter int AW             = 11,
  parameter int DW             = 16,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          ram_wren,
  output logic [AW-1:0] ram_wraddr,
  output logic [DW-1:0] ram_di,
  output logic          ram_rden,
  output logic [AW-1:0] ram_rdaddr,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic {
    S_CLEAR,
    S_SERVE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          last_q, last_d;
  logic          tag_vld_q, tag_vld_d;
  logic          tag_own_q, tag_own_d;

  logic          gnt0, gnt1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    last_d     = last_q;
    tag_vld_d  = 1'b0;
    tag_own_d  = tag_own_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    ram_wren   = 1'b0;
    ram_wraddr = '0;
    ram_di     = '0;
    ram_rden   = 1'b0;
    ram_rdaddr = '0;

    unique case (state_q)
      S_CLEAR: begin
        ram_wren   = 1'b1;
        ram_wraddr = clr_addr_q;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == {AW{1'b1}}) begin
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        // Under contention the side that did not win last goes next.
        gnt0 = req0_valid & (~req1_valid | last_q);
        gnt1 = req1_valid & (~req0_valid | ~last_q);
        sel_we    = gnt1 ? req1_we    : req0_we;
        sel_addr  = gnt1 ? req1_addr  : req0_addr;
        sel_wdata = gnt1 ? req1_wdata : req0_wdata;
        if (gnt0 | gnt1) begin
          last_d = gnt1;
          if (sel_we) begin
            ram_wren   = 1'b1;
            ram_wraddr = sel_addr;
            ram_di     = sel_wdata;
          end else begin
            ram_rden   = 1'b1;
            ram_rdaddr = sel_addr;
            tag_vld_d  = 1'b1;
            tag_own_d  = gnt1;
          end
        end
      end
    endcase

    req0_ready = gnt0;
    req1_ready = gnt1;
    rsp0_valid = tag_vld_q & ~tag_own_q;
    rsp1_valid = tag_vld_q & tag_own_q;

    // Outputs are quiet for the whole reset cycle, including a
    // response that would otherwise land on it.
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      ram_wren   = 1'b0;
      ram_wraddr = '0;
      ram_di     = '0;
      ram_rden   = 1'b0;
      ram_rdaddr = '0;
    end

    rsp0_rdata = rsp0_valid ? ram_do : '0;
    rsp1_rdata = rsp1_valid ? ram_do : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? S_CLEAR : S_SERVE;
      clr_addr_q <= '0;
      last_q     <= 1'b1;
      tag_vld_q  <= 1'b0;
      tag_own_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      last_q     <= last_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
    end
  end

endmodule
